// File: rtl/clock_divider_bank.sv
// clock_divider_bank: per-channel programmable enable strobe and square-wave divider with glitch-free reload
module clock_divider_bank #(
   parameter int CHANNELS = 4,
   parameter int WIDTH = 16,
   parameter int DEFAULT_DIV = 2,
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic                sync,
   input  logic                load,
   input  logic [CH_W-1:0]     load_ch,
   input  logic [WIDTH-1:0]    load_div,
   output logic [CHANNELS-1:0] enable,
   output logic [CHANNELS-1:0] square
);
   logic [WIDTH-1:0] cnt_q [CHANNELS];
   logic [WIDTH-1:0] cnt_d [CHANNELS];
   logic [WIDTH-1:0] div_q [CHANNELS];
   logic [WIDTH-1:0] div_d [CHANNELS];
   logic [WIDTH-1:0] pend_q [CHANNELS];
   logic [WIDTH-1:0] pend_d [CHANNELS];
   logic [CHANNELS-1:0] pv_q, pv_d, en_q, en_d, sq_q, sq_d, sel;
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         sel[i] = load && (load_ch == CH_W'(i));
         cnt_d[i] = cnt_q[i];
         div_d[i] = div_q[i];
         pend_d[i] = pend_q[i];
         pv_d[i] = pv_q[i];
         sq_d[i] = sq_q[i];
         en_d[i] = 1'b0;
         if (sync) begin
            cnt_d[i] = '0;
            sq_d[i] = 1'b0;
            pv_d[i] = 1'b0;
            div_d[i] = sel[i] ? load_div : (pv_q[i] ? pend_q[i] : div_q[i]);
         end else begin
            // divisors 0 and 1 wrap on every running edge
            if (run && (div_q[i] <= WIDTH'(1) || cnt_q[i] == div_q[i] - WIDTH'(1))) begin
               cnt_d[i] = '0;
               en_d[i] = 1'b1;
               sq_d[i] = ~sq_q[i];
               div_d[i] = pv_q[i] ? pend_q[i] : div_q[i];
               pv_d[i] = 1'b0;
            end else if (run) begin
               cnt_d[i] = cnt_q[i] + WIDTH'(1);
            end
            if (sel[i]) begin
               pend_d[i] = load_div;
               pv_d[i] = 1'b1;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= '0;
            div_q[i] <= WIDTH'(DEFAULT_DIV);
            pend_q[i] <= '0;
         end
         pv_q <= '0;
         en_q <= '0;
         sq_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         div_q <= div_d;
         pend_q <= pend_d;
         pv_q <= pv_d;
         en_q <= en_d;
         sq_q <= sq_d;
      end
   end
   assign enable = en_q;
   assign square = sq_q;
endmodule

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank: randomized and directed checks of clock_divider_bank against a countdown reference model
module tb_clock_divider_bank;
   localparam int CH = 3;
   localparam int W = 8;
   localparam int DD = 2;
   localparam int CW = 2;
   logic clk = 1'b0;
   logic reset, run, sync, load;
   logic [CW-1:0] load_ch;
   logic [W-1:0] load_div;
   logic [CH-1:0] enable, square;
   int n_cmp = 0;
   int n_bad = 0;
   always #5 clk = ~clk;
   clock_divider_bank #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DD)) dut (
      .clk(clk), .reset(reset), .run(run), .sync(sync), .load(load),
      .load_ch(load_ch), .load_div(load_div), .enable(enable), .square(square)
   );
   task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask
   // model: per channel, running edges left until the next pulse
   int left [CH];
   int mdiv [CH];
   int pend [CH];
   bit pv [CH];
   logic [CH-1:0] m_en, m_sq;
   bit live = 0;
   function automatic int eff(input int d);
      return d < 2 ? 1 : d;
   endfunction
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CH; i++) begin
            mdiv[i] = DD;
            pv[i] = 0;
            left[i] = eff(DD);
         end
         m_en = '0;
         m_sq = '0;
         live = 1;
      end else if (sync) begin
         for (int i = 0; i < CH; i++) begin
            if (pv[i]) mdiv[i] = pend[i];
            if (load && load_ch == i) mdiv[i] = load_div;
            pv[i] = 0;
            left[i] = eff(mdiv[i]);
         end
         m_en = '0;
         m_sq = '0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            m_en[i] = 1'b0;
            if (run) begin
               left[i]--;
               if (left[i] == 0) begin
                  m_en[i] = 1'b1;
                  m_sq[i] = ~m_sq[i];
                  if (pv[i]) mdiv[i] = pend[i];
                  pv[i] = 0;
                  left[i] = eff(mdiv[i]);
               end
            end
            if (load && load_ch == i) begin
               pend[i] = load_div;
               pv[i] = 1;
            end
         end
      end
      #1;
      if (live) begin
         check("model_enable", enable, m_en);
         check("model_square", square, m_sq);
      end
   end
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic ld(input int ch, input int d);
      load = 1'b1;
      load_ch = CW'(ch);
      load_div = W'(d);
      @(negedge clk);
      load = 1'b0;
   endtask
   initial begin
      int k;
      reset = 1'b1; run = 1'b0; sync = 1'b0; load = 1'b0; load_ch = '0; load_div = '0;
      cyc(2);
      check("reset_enable", enable, 3'b000);
      check("reset_square", square, 3'b000);
      reset = 1'b0; run = 1'b1;
      @(posedge clk); #2 check("edge1_enable", enable, 3'b000);
      @(posedge clk); #2 check("edge2_enable", enable, 3'b111);
      check("edge2_square", square, 3'b111);
      @(negedge clk);
      ld(1, 5);
      cyc(12);
      ld(2, 3);
      ld(2, 7);
      cyc(20);
      k = 0;
      while (enable[2] !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (k >= 50) begin
         n_bad++;
         $display("FAIL wait_ch2_pulse: no pulse in %0d cycles, expected one within 50", k);
      end
      cyc(6);
      ld(2, 4);
      cyc(16);
      ld(0, 1);
      cyc(6);
      repeat (3) begin
         @(posedge clk); #2 check("passthru_d1_en0", {2'b00, enable[0]}, 3'b001);
      end
      @(negedge clk);
      ld(0, 0);
      cyc(4);
      repeat (2) begin
         @(posedge clk); #2 check("passthru_d0_en0", {2'b00, enable[0]}, 3'b001);
      end
      @(negedge clk);
      ld(0, 4);
      cyc(12);
      ld(0, 2);
      ld(1, 2);
      cyc(13);
      run = 1'b0;
      cyc(3);
      sync = 1'b1; load = 1'b1; load_ch = 2'd2; load_div = 8'd6;
      @(negedge clk);
      sync = 1'b0; load = 1'b0;
      check("sync_enable", enable, 3'b000);
      check("sync_square", square, 3'b000);
      run = 1'b1;
      cyc(20);
      ld(1, 9);
      cyc(1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      ld(3, 9);
      @(posedge clk); #2 check("post_reset_edge2_en", enable, 3'b111);
      @(negedge clk);
      cyc(10);
      repeat (3000) begin
         reset = ($urandom_range(0, 499) == 0);
         run = ($urandom_range(0, 9) != 0);
         sync = ($urandom_range(0, 59) == 0);
         load = ($urandom_range(0, 5) == 0);
         load_ch = CW'($urandom_range(0, 3));
         load_div = ($urandom_range(0, 19) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 9));
         @(negedge clk);
      end
      reset = 1'b0; load = 1'b0; sync = 1'b0;
      cyc(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
